// File: rtl/reconf_fifo_writer_if.sv
// Handshake bundle between the mode-control logic and the PLL reconfiguration FIFO write port.
// The master modport is the writer itself; the slave modport is its environment.
interface reconf_fifo_writer_if;
   logic [3:0] resolution;
   logic       force_vga;
   logic       generate_video;
   logic       generate_timing;
   logic       reset_pll_req;
   logic       wrfull;
   logic       wrreq;
   logic [7:0] data;
   logic       busy;
   logic       invalid_res;

   modport master (
      input  resolution, force_vga, generate_video, generate_timing,
      input  reset_pll_req, wrfull,
      output wrreq, data, busy, invalid_res
   );

   modport slave (
      output resolution, force_vga, generate_video, generate_timing,
      output reset_pll_req, wrfull,
      input  wrreq, data, busy, invalid_res
   );
endinterface

// File: rtl/reconf_fifo_writer.sv
// Turns mode changes and PLL-reset requests into one command byte per change in the
// reconfiguration FIFO, spacing commands by a hold-off so each reconfiguration can finish.
module reconf_fifo_writer #(
   parameter int HOLDOFF_CYCLES = 1024,
   parameter int RES_MAX        = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   reconf_fifo_writer_if.master bus
);

   typedef enum logic {IDLE, HOLDOFF} state_t;

   localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);
   localparam logic [3:0]  RES_LIMIT = 4'(RES_MAX);

   state_t      state_q, state_d;
   logic [6:0]  sentCfg_q, sentCfg_d;
   logic        pllPending_q, pllPending_d;
   logic        initPending_q, initPending_d;
   logic [15:0] cnt_q, cnt_d;
   logic        wrreq_q, wrreq_d;
   logic [7:0]  data_q, data_d;
   logic        busy_q, busy_d;
   logic        invalidRes_q, invalidRes_d;

   logic [6:0]  curCfg;
   logic [6:0]  selCfg;
   logic        cfgValid;
   logic        cfgChanged;
   logic        pending;

   // An invalid resolution hides the whole requested configuration, flags included;
   // a pll/init-driven write then re-sends the last configuration that was accepted.
   assign curCfg     = {bus.force_vga, bus.generate_video, bus.generate_timing, bus.resolution};
   assign cfgValid   = (bus.resolution <= RES_LIMIT);
   assign cfgChanged = cfgValid && (curCfg != sentCfg_q);
   assign pending    = initPending_q | pllPending_q | cfgChanged;
   assign selCfg     = cfgValid ? curCfg : sentCfg_q;

   always_comb begin
      state_d       = state_q;
      sentCfg_d     = sentCfg_q;
      pllPending_d  = pllPending_q | bus.reset_pll_req;
      initPending_d = initPending_q;
      cnt_d         = cnt_q;
      wrreq_d       = 1'b0;
      data_d        = data_q;
      busy_d        = (state_q != IDLE) | pending;
      invalidRes_d  = ~cfgValid;

      case (state_q)
         IDLE: begin
            if (pending && !bus.wrfull) begin
               wrreq_d       = 1'b1;
               data_d        = {selCfg[6], pllPending_q, selCfg[5:0]};
               sentCfg_d     = selCfg;
               // A request arriving with this write is not carried by it and must survive.
               pllPending_d  = bus.reset_pll_req;
               initPending_d = 1'b0;
               cnt_d         = HOLD_LOAD;
               state_d       = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (cnt_q == 16'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         sentCfg_q     <= 7'd0;
         pllPending_q  <= 1'b0;
         initPending_q <= 1'b1;
         cnt_q         <= 16'd0;
         wrreq_q       <= 1'b0;
         data_q        <= 8'h00;
         busy_q        <= 1'b1;
         invalidRes_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         sentCfg_q     <= sentCfg_d;
         pllPending_q  <= pllPending_d;
         initPending_q <= initPending_d;
         cnt_q         <= cnt_d;
         wrreq_q       <= wrreq_d;
         data_q        <= data_d;
         busy_q        <= busy_d;
         invalidRes_q  <= invalidRes_d;
      end
   end

   assign bus.wrreq       = wrreq_q;
   assign bus.data        = data_q;
   assign bus.busy        = busy_q;
   assign bus.invalid_res = invalidRes_q;

endmodule
